// File: rtl/dummy_scan_engine_mp.sv
// Multi-pass dummy (flush) row scan engine: sweeps a row window issuing reset pulses, N passes.
// Optional statistics counters are enabled with the DUMMY_SCAN_STATS_EN macro.
module dummy_scan_engine_mp #(
    parameter int unsigned NUM_ROWS = 2048,
    parameter int unsigned ROW_W    = 12,
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned PW_W     = 8,
    parameter int unsigned PASS_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_auto_en,
    input  logic [ROW_W-1:0]    cfg_row_start,
    input  logic [ROW_W-1:0]    cfg_row_end,
    input  logic [PW_W-1:0]     cfg_pulse_w,
    input  logic [PW_W-1:0]     cfg_gap_w,
    input  logic [PASS_W-1:0]   cfg_passes,
    input  logic                trigger,
    input  logic                abort,
    input  logic                readout_busy,
    output logic                dummy_active,
    output logic                dummy_complete,
    output logic                dummy_aborted,
    output logic [ROW_W-1:0]    row_addr,
    output logic                reset_pulse,
    output logic                dummy_auto_src,
    output logic [PASS_W-1:0]   pass_idx
`ifdef DUMMY_SCAN_STATS_EN
    ,
    output logic [15:0]         stat_done_cnt,
    output logic [15:0]         stat_abort_cnt,
    output logic [15:0]         stat_drop_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(NUM_ROWS - 1);

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                auto_req_c;
    logic                req_q, req_d;
    logic                req_auto_q, req_auto_d;
    logic                pend_q, pend_d;
    logic                pend_auto_q, pend_auto_d;
    logic                pend_live_c;
    logic [ROW_W-1:0]    start_sh_q, start_sh_d;
    logic [ROW_W-1:0]    end_sh_q, end_sh_d;
    logic [PW_W-1:0]     pw_sh_q, pw_sh_d;
    logic [PW_W-1:0]     gw_sh_q, gw_sh_d;
    logic [PASS_W-1:0]   passes_sh_q, passes_sh_d;
    logic [PW_W-1:0]     cnt_q, cnt_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic                src_q, src_d;
    logic                active_q, active_d;
    logic                pulse_q, pulse_d;
    logic                complete_q, complete_d;
    logic                aborted_q, aborted_d;
    logic                adv_c;
    logic [ROW_W-1:0]    start_clamp_c, end_clamp_c;
    logic [PW_W-1:0]     pw_eff_c;
    logic [PASS_W-1:0]   passes_eff_c;

    assign start_clamp_c = (cfg_row_start > ROW_MAX) ? ROW_MAX : cfg_row_start;
    assign end_clamp_c   = (cfg_row_end > ROW_MAX) ? ROW_MAX : cfg_row_end;
    assign pw_eff_c      = (cfg_pulse_w == '0) ? PW_W'(1) : cfg_pulse_w;
    assign passes_eff_c  = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
    assign pend_live_c   = pend_q && !abort;

    // Free-running auto-period timer and registered start-request stage
    always_comb begin
        auto_req_c = 1'b0;
        period_d   = '0;
        if (cfg_auto_en && (cfg_period != '0)) begin
            if (period_q >= (cfg_period - PERIOD_W'(1))) begin
                auto_req_c = 1'b1;
            end else begin
                period_d = period_q + PERIOD_W'(1);
            end
        end
        req_d      = trigger | auto_req_c;
        req_auto_d = auto_req_c & ~trigger;
    end

    // Scan FSM next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_auto_d = pend_auto_q;
        start_sh_d  = start_sh_q;
        end_sh_d    = end_sh_q;
        pw_sh_d     = pw_sh_q;
        gw_sh_d     = gw_sh_q;
        passes_sh_d = passes_sh_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        pass_d      = pass_q;
        src_d       = src_q;
        complete_d  = 1'b0;
        aborted_d   = 1'b0;
        adv_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (abort) begin
                    pend_d = 1'b0;
                end
                if ((req_q || pend_live_c) && !readout_busy) begin
                    start_sh_d  = start_clamp_c;
                    end_sh_d    = end_clamp_c;
                    pw_sh_d     = pw_eff_c;
                    gw_sh_d     = cfg_gap_w;
                    passes_sh_d = passes_eff_c;
                    cnt_d       = pw_eff_c - PW_W'(1);
                    row_d       = start_clamp_c;
                    pass_d      = '0;
                    src_d       = pend_live_c ? pend_auto_q : req_auto_q;
                    pend_d      = 1'b0;
                    state_d     = PULSE;
                end else if (req_q && !pend_q && !abort) begin
                    pend_d      = 1'b1;
                    pend_auto_d = req_auto_q;
                end
            end
            PULSE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == '0) begin
                    if (gw_sh_q != '0) begin
                        cnt_d   = gw_sh_q - PW_W'(1);
                        state_d = GAP;
                    end else begin
                        adv_c = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - PW_W'(1);
                end
            end
            GAP: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == '0) begin
                    adv_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - PW_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Row advance wraps at the physical row count, so start > end scans across the wrap
        if (adv_c) begin
            if (row_q != end_sh_q) begin
                row_d   = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
                cnt_d   = pw_sh_q - PW_W'(1);
                state_d = PULSE;
            end else if (pass_q < (passes_sh_q - PASS_W'(1))) begin
                pass_d  = pass_q + PASS_W'(1);
                row_d   = start_sh_q;
                cnt_d   = pw_sh_q - PW_W'(1);
                state_d = PULSE;
            end else begin
                complete_d = 1'b1;
                state_d    = DONE;
            end
        end

        active_d = (state_d == PULSE) || (state_d == GAP);
        pulse_d  = (state_d == PULSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            period_q    <= '0;
            req_q       <= 1'b0;
            req_auto_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_auto_q <= 1'b0;
            start_sh_q  <= '0;
            end_sh_q    <= '0;
            pw_sh_q     <= '0;
            gw_sh_q     <= '0;
            passes_sh_q <= '0;
            cnt_q       <= '0;
            row_q       <= '0;
            pass_q      <= '0;
            src_q       <= 1'b0;
            active_q    <= 1'b0;
            pulse_q     <= 1'b0;
            complete_q  <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            req_q       <= req_d;
            req_auto_q  <= req_auto_d;
            pend_q      <= pend_d;
            pend_auto_q <= pend_auto_d;
            start_sh_q  <= start_sh_d;
            end_sh_q    <= end_sh_d;
            pw_sh_q     <= pw_sh_d;
            gw_sh_q     <= gw_sh_d;
            passes_sh_q <= passes_sh_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            pass_q      <= pass_d;
            src_q       <= src_d;
            active_q    <= active_d;
            pulse_q     <= pulse_d;
            complete_q  <= complete_d;
            aborted_q   <= aborted_d;
        end
    end

    assign dummy_active   = active_q;
    assign reset_pulse    = pulse_q;
    assign dummy_complete = complete_q;
    assign dummy_aborted  = aborted_q;
    assign row_addr       = row_q;
    assign pass_idx       = pass_q;
    assign dummy_auto_src = src_q;

`ifdef DUMMY_SCAN_STATS_EN
    logic [15:0] done_cnt_q, abort_cnt_q, drop_cnt_q;
    logic        drop_c;

    // A request is dropped when the engine is busy scanning or one is already held
    assign drop_c = req_q && ((state_q != IDLE) || pend_live_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt_q  <= '0;
            abort_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (complete_d && (done_cnt_q != 16'hFFFF)) begin
                done_cnt_q <= done_cnt_q + 16'd1;
            end
            if (aborted_d && (abort_cnt_q != 16'hFFFF)) begin
                abort_cnt_q <= abort_cnt_q + 16'd1;
            end
            if (drop_c && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign stat_done_cnt  = done_cnt_q;
    assign stat_abort_cnt = abort_cnt_q;
    assign stat_drop_cnt  = drop_cnt_q;
`endif

endmodule
